fifo_shift_reg: RTL and testbench

Single-clock, multi-lane byte FIFO built as a shift register, used by the network interface unit as its bus RX and TX buffers. Each clock it accepts a variable number of entries on parallel input lanes (head) and releases a variable number of entries on parallel output lanes (tail). The oldest stored entries are always visible in order on the output lanes. It reports live free-space and occupancy counts so producers and consumers can size transfers combinationally.

---
 rtl/fifo_shift_reg_if.sv | 33 +++
 rtl/fifo_shift_reg.sv | 108 ++++++++++
 tb/tb_fifo_shift_reg.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_shift_reg_if.sv
// ============================================================================
// Module      : fifo_shift_reg_if
// Description : Head/tail lane bundle for the multi-lane shift-register FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_shift_reg_if #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 256,
    parameter int INPUTS  = 32,
    parameter int OUTPUTS = 36,
    parameter int CW      = $clog2(DEPTH) + 1
);
    logic [INPUTS-1:0]             push;
    logic [INPUTS-1:0][WIDTH-1:0]  inp;
    logic [CW-1:0]                 src_num_avail;
    logic [OUTPUTS-1:0]            pop;
    logic [OUTPUTS-1:0][WIDTH-1:0] oup;
    logic [CW-1:0]                 dst_num_avail;

    modport master (
        output push, inp, pop,
        input  src_num_avail, oup, dst_num_avail
    );

    modport slave (
        input  push, inp, pop,
        output src_num_avail, oup, dst_num_avail
    );
endinterface

`default_nettype wire

// File: rtl/fifo_shift_reg.sv
// ============================================================================
// Module      : fifo_shift_reg
// Description : Multi-lane byte FIFO as a shift register; mem[0] is the oldest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_shift_reg #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 256,
    parameter int INPUTS  = 32,
    parameter int OUTPUTS = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_shift_reg_if.slave      bus
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;

    logic [CW-1:0]    w_p;
    logic [CW-1:0]    w_q;
    logic             w_p_run;
    logic             w_q_run;
    logic [CW-1:0]    w_free;
    logic [CW-1:0]    w_pe;
    logic [CW-1:0]    w_qe;
    logic [CW-1:0]    w_base;
    logic [WIDTH-1:0] w_mem_next [DEPTH];

    // Only the unbroken run of requests starting at lane 0 counts.
    always_comb begin
        w_p     = '0;
        w_p_run = 1'b1;
        for (int i = 0; i < INPUTS; i++) begin
            if (w_p_run && bus.push[i]) begin
                w_p = w_p + CW'(1);
            end else begin
                w_p_run = 1'b0;
            end
        end
    end

    always_comb begin
        w_q     = '0;
        w_q_run = 1'b1;
        for (int i = 0; i < OUTPUTS; i++) begin
            if (w_q_run && bus.pop[i]) begin
                w_q = w_q + CW'(1);
            end else begin
                w_q_run = 1'b0;
            end
        end
    end

    // Free space is judged before this cycle's pops take effect.
    assign w_free = C_DEPTH - r_count;
    assign w_qe   = (w_q < r_count) ? w_q : r_count;
    assign w_pe   = (w_p < w_free)  ? w_p : w_free;
    assign w_base = r_count - w_qe;

    // The modulo wrap only touches slots at or above the new base, which are
    // either overwritten by the push or lie beyond the new count.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_mem_next[k] = r_mem[k];
            for (int s = 1; s <= OUTPUTS; s++) begin
                if (w_qe == CW'(s)) begin
                    w_mem_next[k] = r_mem[(k + s) % DEPTH];
                end
            end
            for (int j = 0; j < INPUTS; j++) begin
                if ((CW'(j) < w_pe) && (CW'(k) == (w_base + CW'(j)))) begin
                    w_mem_next[k] = bus.inp[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= r_count - w_qe + w_pe;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= w_mem_next[k];
        end
    end

    generate
        for (genvar i = 0; i < OUTPUTS; i++) begin : g_oup
            assign bus.oup[i] = (CW'(i) < r_count) ? r_mem[i] : '0;
        end
    endgenerate

    assign bus.dst_num_avail = r_count;
    assign bus.src_num_avail = w_free;

endmodule

`default_nettype wire

// File: tb/tb_fifo_shift_reg.sv
// ============================================================================
// Module      : tb_fifo_shift_reg
// Description : Directed scoreboard bench for the multi-lane shift-register FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_shift_reg;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 256;
    localparam int INPUTS  = 32;
    localparam int OUTPUTS = 36;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_shift_reg_if #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .INPUTS(INPUTS), .OUTPUTS(OUTPUTS), .CW(CW)
    ) bus ();

    fifo_shift_reg #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .INPUTS(INPUTS), .OUTPUTS(OUTPUTS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int                         when;
        string                      name;
        int                         cnt;
        logic [OUTPUTS*WIDTH-1:0]   lanes;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] eb [$];
    logic [7:0] din [INPUTS];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_state(input string name, input int cnt);
        exp_t e;
        e.when  = cyc + 1;
        e.name  = name;
        e.cnt   = cnt;
        e.lanes = '0;
        for (int k = 0; k < eb.size() && k < OUTPUTS; k++) begin
            e.lanes[k*WIDTH +: WIDTH] = eb[k];
        end
        sb.push_back(e);
        eb.delete();
    endtask

    task automatic step(input logic r, input logic [INPUTS-1:0] pm,
                        input logic [OUTPUTS-1:0] qm, input string name, input int cnt);
        rst      = r;
        bus.push = pm;
        bus.pop  = qm;
        for (int j = 0; j < INPUTS; j++) bus.inp[j] = din[j];
        expect_state(name, cnt);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.push = '0;
        bus.pop  = '0;
    endtask

    // Monitor: state is checked on the falling edge of the cycle it should appear in.
    always @(negedge clk) begin
        exp_t                     e;
        logic [OUTPUTS*WIDTH-1:0] got;
        got = bus.oup;
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            e = sb.pop_front();
            if (e.when != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: checked in cycle %0d, required cycle %0d", e.name, cyc, e.when);
            end else begin
                checks++;
                if (bus.dst_num_avail !== CW'(e.cnt)) begin
                    errors++;
                    $display("FAIL %s dst_num_avail: got %0d, expected %0d",
                             e.name, bus.dst_num_avail, e.cnt);
                end
                checks++;
                if (bus.src_num_avail !== CW'(DEPTH - e.cnt)) begin
                    errors++;
                    $display("FAIL %s src_num_avail: got %0d, expected %0d",
                             e.name, bus.src_num_avail, DEPTH - e.cnt);
                end
                checks++;
                if (got !== e.lanes) begin
                    errors++;
                    $display("FAIL %s oup: got %h, expected %h", e.name, got, e.lanes);
                end
            end
        end
    end

    initial begin
        int cnt;
        int v;
        rst      = 1'b0;
        bus.push = '0;
        bus.pop  = '0;
        bus.inp  = '0;

        for (int j = 0; j < INPUTS; j++) din[j] = 8'(j + 1);
        step(1'b1, '1, '1, "reset", 0);

        for (int k = 1; k <= 5; k++) eb.push_back(8'(k));
        step(1'b0, 32'h0000_001F, '0, "push5", 5);

        for (int j = 0; j < INPUTS; j++) din[j] = 8'h77;
        din[0] = 8'h0A; din[1] = 8'h0B; din[2] = 8'h0C;
        eb.push_back(8'h03); eb.push_back(8'h04); eb.push_back(8'h05);
        eb.push_back(8'h0A); eb.push_back(8'h0B); eb.push_back(8'h0C);
        step(1'b0, 32'h7, 36'h3, "pop2_push3", 6);

        step(1'b1, '1, '0, "reset_mid", 0);

        for (int j = 0; j < INPUTS; j++) din[j] = 8'(8'h10 + j);
        eb.push_back(8'h10); eb.push_back(8'h11);
        step(1'b0, 32'hB, '0, "push_1011", 2);

        eb.push_back(8'h11);
        step(1'b0, '0, 36'h5, "pop_0101", 1);

        for (int j = 0; j < INPUTS; j++) din[j] = 8'(8'h21 + j);
        eb.push_back(8'h21); eb.push_back(8'h22); eb.push_back(8'h23);
        step(1'b0, 32'h7, 36'h1, "pop1_push3", 3);

        step(1'b0, '0, '1, "over_pop", 0);

        for (int j = 0; j < INPUTS; j++) din[j] = 8'(8'h31 + j);
        eb.push_back(8'h31); eb.push_back(8'h32);
        step(1'b0, 32'h3, '1, "push2_pop_empty", 2);

        step(1'b0, '0, 36'h3, "drain2", 0);

        // Fill with bytes 0..255 in order, 32 per cycle.
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < INPUTS; j++) din[j] = 8'(b * 32 + j);
            cnt = 32 * (b + 1);
            for (int k = 0; k < cnt && k < OUTPUTS; k++) eb.push_back(8'(k));
            step(1'b0, '1, '0, $sformatf("fill%0d", b), cnt);
        end

        for (int j = 0; j < INPUTS; j++) din[j] = 8'hEE;
        for (int k = 0; k < OUTPUTS; k++) eb.push_back(8'(k));
        step(1'b0, '1, '0, "push_full", 256);

        for (int k = 0; k < OUTPUTS; k++) eb.push_back(8'(k + 4));
        step(1'b0, '1, 36'hF, "push_full_pop4", 252);

        for (int j = 0; j < INPUTS; j++) din[j] = 8'(8'hC0 + j);
        for (int k = 0; k < OUTPUTS; k++) eb.push_back(8'(k + 4));
        step(1'b0, '1, '0, "refill4", 256);

        // Stored sequence is now 4..255 followed by C0..C3.
        for (int p = 1; p <= 7; p++) begin
            cnt = 256 - 36 * p;
            for (int k = 0; k < cnt && k < OUTPUTS; k++) begin
                v = 4 + 36 * p + k;
                eb.push_back((v < 256) ? 8'(v) : 8'(8'hC0 + v - 256));
            end
            step(1'b0, '0, '1, $sformatf("drain_full%0d", p), cnt);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
